// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump redirect flushes,
// multi-cycle FPU stalls and global trap/CSR flushes, plus a saturating
// count of front-end stall cycles.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,

    input  logic [4:0]  rs1_addr_ID,
    input  logic [4:0]  rs2_addr_ID,
    input  logic [4:0]  rs3_addr_ID,
    input  logic        rs1_float_ID,
    input  logic        rs2_float_ID,
    input  logic        rs3_en_ID,

    input  logic [4:0]  rd_addr_EX,
    input  logic        regW_en_EX,
    input  logic        rsW_float_EX,
    input  logic        mem_read_EX,
    input  logic        fpu_start_EX,
    input  logic [3:0]  fpu_lat_EX,
    input  logic        redirect_EX,
    input  logic        flush_all,

    output logic        en_IF,
    output logic        en_IF_ID,
    output logic        en_ID_EX,
    output logic        en_EX_MEM,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic        flush_EX_MEM,
    output logic        fpu_busy,
    output logic        fpu_done,
    output logic [15:0] stall_cnt
);

    typedef enum logic {
        RUN      = 1'b0,
        FPU_BUSY = 1'b1
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [3:0] cnt;
    logic [3:0] next_cnt;

    logic ex_load;
    logic hit_rs1;
    logic hit_rs2;
    logic hit_rs3;
    logic load_use;
    logic fpu_long;

    // An EX load can only create a hazard if it really writes a register;
    // integer x0 is hardwired and never a real destination, FP f0 is.
    assign ex_load  = mem_read_EX & regW_en_EX & (rsW_float_EX | (rd_addr_EX != 5'd0));
    assign hit_rs1  = ex_load & (rd_addr_EX == rs1_addr_ID) & (rsW_float_EX == rs1_float_ID);
    assign hit_rs2  = ex_load & (rd_addr_EX == rs2_addr_ID) & (rsW_float_EX == rs2_float_ID);
    // rs3 only exists for fused FP ops, so it is always an FP register.
    assign hit_rs3  = ex_load & rs3_en_ID & (rd_addr_EX == rs3_addr_ID) & rsW_float_EX;
    assign load_use = hit_rs1 | hit_rs2 | hit_rs3;

    // Latencies of 0 or 1 complete within the normal EX cycle.
    assign fpu_long = fpu_start_EX & (fpu_lat_EX >= 4'd2);

    // Combinational stage controls and next-state selection, in priority order.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        en_IF        = 1'b1;
        en_IF_ID     = 1'b1;
        en_ID_EX     = 1'b1;
        en_EX_MEM    = 1'b1;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        fpu_busy     = 1'b0;
        fpu_done     = 1'b0;
        next_state   = state;
        next_cnt     = cnt;

        if (!rst) begin
            en_IF        = 1'b0;
            en_IF_ID     = 1'b0;
            en_ID_EX     = 1'b0;
            en_EX_MEM    = 1'b0;
            flush_IF_ID  = 1'b1;
            flush_ID_EX  = 1'b1;
            flush_EX_MEM = 1'b1;
        end else begin
            fpu_busy = (state == FPU_BUSY);
            if (flush_all) begin
                // Trap/CSR flush wins everywhere and abandons any FPU wait.
                flush_IF_ID  = 1'b1;
                flush_ID_EX  = 1'b1;
                flush_EX_MEM = 1'b1;
                next_state   = RUN;
                next_cnt     = 4'd0;
            end else begin
                case (state)
                    RUN: begin
                        if (fpu_long) begin
                            en_IF      = 1'b0;
                            en_IF_ID   = 1'b0;
                            en_ID_EX   = 1'b0;
                            en_EX_MEM  = 1'b0;
                            next_cnt   = fpu_lat_EX - 4'd1;
                            next_state = FPU_BUSY;
                        end else if (redirect_EX) begin
                            flush_IF_ID = 1'b1;
                            flush_ID_EX = 1'b1;
                        end else if (load_use) begin
                            // Hold IF and ID, let EX advance with a bubble behind it.
                            en_IF       = 1'b0;
                            en_IF_ID    = 1'b0;
                            flush_ID_EX = 1'b1;
                        end
                    end
                    FPU_BUSY: begin
                        if (cnt != 4'd1) begin
                            en_IF     = 1'b0;
                            en_IF_ID  = 1'b0;
                            en_ID_EX  = 1'b0;
                            en_EX_MEM = 1'b0;
                            next_cnt  = cnt - 4'd1;
                        end else begin
                            fpu_done   = 1'b1;
                            next_cnt   = 4'd0;
                            next_state = RUN;
                        end
                    end
                    default: begin
                        next_state = RUN;
                        next_cnt   = 4'd0;
                    end
                endcase
            end
        end
    end

    // State, FPU countdown and saturating stall counter.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (!rst) begin
            state     <= RUN;
            cnt       <= 4'd0;
            stall_cnt <= 16'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (!en_IF && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed corner cases, constrained
// random traffic and a long FPU stall run, all compared cycle by cycle
// against a behavioural model that tracks the FPU release as a cycle number.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_addr_ID, rs2_addr_ID, rs3_addr_ID;
    logic        rs1_float_ID, rs2_float_ID, rs3_en_ID;
    logic [4:0]  rd_addr_EX;
    logic        regW_en_EX, rsW_float_EX, mem_read_EX;
    logic        fpu_start_EX;
    logic [3:0]  fpu_lat_EX;
    logic        redirect_EX, flush_all;
    logic        en_IF, en_IF_ID, en_ID_EX, en_EX_MEM;
    logic        flush_IF_ID, flush_ID_EX, flush_EX_MEM;
    logic        fpu_busy, fpu_done;
    logic [15:0] stall_cnt;

    hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .rs1_addr_ID  (rs1_addr_ID),
        .rs2_addr_ID  (rs2_addr_ID),
        .rs3_addr_ID  (rs3_addr_ID),
        .rs1_float_ID (rs1_float_ID),
        .rs2_float_ID (rs2_float_ID),
        .rs3_en_ID    (rs3_en_ID),
        .rd_addr_EX   (rd_addr_EX),
        .regW_en_EX   (regW_en_EX),
        .rsW_float_EX (rsW_float_EX),
        .mem_read_EX  (mem_read_EX),
        .fpu_start_EX (fpu_start_EX),
        .fpu_lat_EX   (fpu_lat_EX),
        .redirect_EX  (redirect_EX),
        .flush_all    (flush_all),
        .en_IF        (en_IF),
        .en_IF_ID     (en_IF_ID),
        .en_ID_EX     (en_ID_EX),
        .en_EX_MEM    (en_EX_MEM),
        .flush_IF_ID  (flush_IF_ID),
        .flush_ID_EX  (flush_ID_EX),
        .flush_EX_MEM (flush_EX_MEM),
        .fpu_busy     (fpu_busy),
        .fpu_done     (fpu_done),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference model state: absolute cycle of the FPU release, not a countdown.
    int cyc = 0;
    bit fpu_pending = 0;
    int release_at = 0;
    int model_stalls = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit model_load_use();
        logic [4:0] addr [3];
        bit         fp   [3];
        bit         used [3];
        addr = '{rs1_addr_ID, rs2_addr_ID, rs3_addr_ID};
        fp   = '{rs1_float_ID, rs2_float_ID, 1'b1};
        used = '{1'b1, 1'b1, rs3_en_ID};
        for (int k = 0; k < 3; k++) begin
            if (used[k] && mem_read_EX && regW_en_EX && rd_addr_EX == addr[k] &&
                rsW_float_EX == fp[k] && (rsW_float_EX || rd_addr_EX != 5'd0))
                return 1'b1;
        end
        return 1'b0;
    endfunction

    // Inputs are already driven (after a negedge); check, advance the model,
    // then wait for the next negedge.
    task automatic step();
        bit e_if, e_ifid, e_idex, e_exmem, f_ifid, f_idex, f_exmem, busy, done;
        bit long_op;
        #1;
        {e_if, e_ifid, e_idex, e_exmem} = 4'b1111;
        {f_ifid, f_idex, f_exmem, busy, done} = 5'b0;
        long_op = fpu_start_EX && (int'(fpu_lat_EX) >= 2);
        if (!rst) begin
            {e_if, e_ifid, e_idex, e_exmem} = 4'b0000;
            {f_ifid, f_idex, f_exmem} = 3'b111;
        end else if (fpu_pending) begin
            busy = 1;
            if (flush_all) {f_ifid, f_idex, f_exmem} = 3'b111;
            else if (cyc == release_at) done = 1;
            else {e_if, e_ifid, e_idex, e_exmem} = 4'b0000;
        end else begin
            if (flush_all) {f_ifid, f_idex, f_exmem} = 3'b111;
            else if (long_op) {e_if, e_ifid, e_idex, e_exmem} = 4'b0000;
            else if (redirect_EX) {f_ifid, f_idex} = 2'b11;
            else if (model_load_use()) begin
                {e_if, e_ifid} = 2'b00;
                f_idex = 1;
            end
        end
        check("ctl", {7'd0, en_IF, en_IF_ID, en_ID_EX, en_EX_MEM, flush_IF_ID,
                      flush_ID_EX, flush_EX_MEM, fpu_busy, fpu_done},
              {7'd0, e_if, e_ifid, e_idex, e_exmem, f_ifid, f_idex, f_exmem, busy, done});
        check("stall_cnt", stall_cnt, 16'(model_stalls));

        if (!rst) begin
            fpu_pending  = 0;
            model_stalls = 0;
        end else begin
            if (!e_if && model_stalls < 65535) model_stalls++;
            if (flush_all) fpu_pending = 0;
            else if (fpu_pending && cyc == release_at) fpu_pending = 0;
            else if (!fpu_pending && long_op) begin
                fpu_pending = 1;
                release_at  = cyc + int'(fpu_lat_EX) - 1;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b1;
        rs1_addr_ID = 5'd0; rs2_addr_ID = 5'd0; rs3_addr_ID = 5'd0;
        rs1_float_ID = 1'b0; rs2_float_ID = 1'b0; rs3_en_ID = 1'b0;
        rd_addr_EX = 5'd0; regW_en_EX = 1'b0; rsW_float_EX = 1'b0; mem_read_EX = 1'b0;
        fpu_start_EX = 1'b0; fpu_lat_EX = 4'd0; redirect_EX = 1'b0; flush_all = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            idle_inputs();
            step();
        end
    endtask

    task automatic fpu_op(input logic [3:0] lat);
        idle_inputs();
        fpu_start_EX = 1'b1;
        fpu_lat_EX   = lat;
        step();
    endtask

    task automatic set_load(input logic [4:0] rd, input logic fp);
        mem_read_EX = 1'b1; regW_en_EX = 1'b1; rd_addr_EX = rd; rsW_float_EX = fp;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        step();
        rst = 1'b0;
        step();

        // Integer load-use on rs2: one bubble cycle, counter reaches 1.
        idle_inputs(); set_load(5'd5, 1'b0); rs2_addr_ID = 5'd5; step();
        idle_steps(1);
        check("lu_stall_cnt", stall_cnt, 16'd1);

        // Loads to integer x0 and FP-vs-integer mismatch: no stall.
        idle_inputs(); set_load(5'd0, 1'b0); rs1_addr_ID = 5'd0; step();
        idle_inputs(); set_load(5'd5, 1'b1); rs1_addr_ID = 5'd5; step();
        // FP f0 load feeding rs3 does stall.
        idle_inputs(); set_load(5'd0, 1'b1); rs3_en_ID = 1'b1; step();
        idle_inputs(); set_load(5'd7, 1'b1); rs3_addr_ID = 5'd7; rs3_en_ID = 1'b0; step();

        // FPU latency 4, then latency 1 and 0 (no stall).
        fpu_op(4'd4);
        idle_steps(4);
        fpu_op(4'd1);
        fpu_op(4'd0);
        fpu_op(4'd2);
        idle_steps(2);

        // Redirect beats load-use; FPU start beats redirect.
        idle_inputs(); set_load(5'd3, 1'b0); rs1_addr_ID = 5'd3; redirect_EX = 1'b1; step();
        idle_inputs(); redirect_EX = 1'b1; fpu_start_EX = 1'b1; fpu_lat_EX = 4'd3; step();
        // Redirect and load-use ignored during the wait.
        idle_inputs(); redirect_EX = 1'b1; set_load(5'd3, 1'b0); rs1_addr_ID = 5'd3; step();
        idle_steps(2);

        // flush_all on the second busy cycle aborts the wait.
        fpu_op(4'd6);
        idle_steps(1);
        idle_inputs(); flush_all = 1'b1; step();
        idle_steps(5);

        // Reset mid-wait aborts too and clears the counter.
        fpu_op(4'd6);
        idle_steps(1);
        idle_inputs(); rst = 1'b0; step();
        idle_steps(5);
        check("rst_stall_cnt", stall_cnt, 16'd0);

        // Constrained random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst          = ($urandom_range(0, 49) != 0);
            rs1_addr_ID  = 5'($urandom_range(0, 3));
            rs2_addr_ID  = 5'($urandom_range(0, 3));
            rs3_addr_ID  = 5'($urandom_range(0, 3));
            rs1_float_ID = 1'($urandom_range(0, 1));
            rs2_float_ID = 1'($urandom_range(0, 1));
            rs3_en_ID    = 1'($urandom_range(0, 1));
            rd_addr_EX   = 5'($urandom_range(0, 3));
            regW_en_EX   = ($urandom_range(0, 3) != 0);
            rsW_float_EX = 1'($urandom_range(0, 1));
            mem_read_EX  = 1'($urandom_range(0, 1));
            fpu_start_EX = ($urandom_range(0, 9) == 0);
            fpu_lat_EX   = 4'($urandom_range(0, 15));
            redirect_EX  = ($urandom_range(0, 5) == 0);
            flush_all    = ($urandom_range(0, 29) == 0);
            step();
        end

        // Back-to-back 15-cycle FPU ops until the stall counter saturates.
        idle_inputs(); rst = 1'b0; step();
        for (int i = 0; i < 70400; i++) begin
            idle_inputs();
            fpu_start_EX = 1'b1;
            fpu_lat_EX   = 4'd15;
            step();
        end
        check("sat_stall_cnt", stall_cnt, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
